// File: rtl/priority_encoder_queue.sv
// priority_encoder_queue: captures one-cycle request pulses into sticky
// pending bits. It presents the highest-index pending request as a W-bit
// code over a valid/ready handshake and clears that bit when the code is
// accepted. The enable input gates capture, transfer and presentation.
module priority_encoder_queue #(
  parameter int W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2**W-1:0]   req,
  input  logic              ready,
  output logic              valid,
  output logic [W-1:0]      code,
  output logic [2**W-1:0]   pending
);

  localparam int N = 2**W;

  logic          fire;
  logic [N-1:0]  clr;
  logic [N-1:0]  pending_n;

  // Index of the highest set bit, or 0 when nothing is set.
  function automatic logic [W-1:0] hi_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Transfer decode and next pending set; a new request on the bit being
  // cleared in the same cycle wins, so that event is presented again.
  always_comb begin
    fire      = valid & ready & en;
    clr       = '0;
    if (fire) clr = N'(1) << code;
    pending_n = (pending & ~clr) | (en ? req : '0);
  end

  // Pending bits and output slot. A held code is never preempted. With
  // enable low the slot is emptied and pending is frozen, so the code is
  // reselected from pending when enable returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      valid   <= 1'b0;
      code    <= '0;
    end else if (en) begin
      pending <= pending_n;
      if (!valid || fire) begin
        valid <= |pending_n;
        code  <= hi_index(pending_n);
      end
    end else begin
      valid <= 1'b0;
      code  <= '0;
    end
  end

endmodule

// File: tb/tb_priority_encoder_queue.sv
// Testbench for priority_encoder_queue: directed vector table walked in
// order from reset, followed by a back-to-back drain sequence.
module tb_priority_encoder_queue;

  localparam int W = 2;
  localparam int N = 2**W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req;
  logic          ready;
  logic          valid;
  logic [W-1:0]  code;
  logic [N-1:0]  pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          rst_n;
    logic          en;
    logic [N-1:0]  req;
    logic          ready;
    logic          exp_valid;
    logic [W-1:0]  exp_code;
    logic [N-1:0]  exp_pending;
    string         name;
  } vec_t;

  vec_t vecs[$];

  priority_encoder_queue #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .ready   (ready),
    .valid   (valid),
    .code    (code),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [N-1:0] rq,
                     input logic rd, input logic v, input logic [W-1:0] c,
                     input logic [N-1:0] p, input string nm);
    vec_t t;
    t.rst_n = r; t.en = e; t.req = rq; t.ready = rd;
    t.exp_valid = v; t.exp_code = c; t.exp_pending = p; t.name = nm;
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] rq,
                      input logic rd);
    @(negedge clk);
    rst_n = r; en = e; req = rq; ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = '0; ready = 1'b1;

    //   rst en req     rdy  valid code pending
    add(0, 1, 4'b1111, 1,   0, 0, 4'b0000, "reset0");
    add(0, 1, 4'b1111, 1,   0, 0, 4'b0000, "reset1");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "post_reset");
    add(1, 1, 4'b0100, 1,   1, 2, 4'b0100, "single_set");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "single_done");
    add(1, 1, 4'b1010, 0,   1, 3, 4'b1010, "bp_hold0");
    add(1, 1, 4'b0000, 0,   1, 3, 4'b1010, "bp_hold1");
    add(1, 1, 4'b0000, 0,   1, 3, 4'b1010, "bp_hold2");
    add(1, 1, 4'b0000, 1,   1, 1, 4'b0010, "bp_next");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "bp_done");
    add(1, 1, 4'b0010, 0,   1, 1, 4'b0010, "np_low");
    add(1, 1, 4'b1000, 0,   1, 1, 4'b1010, "np_nopreempt");
    add(1, 1, 4'b0000, 1,   1, 3, 4'b1000, "np_high_next");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "np_done");
    add(1, 1, 4'b0110, 0,   1, 2, 4'b0110, "en_setup");
    add(1, 0, 4'b0001, 1,   0, 0, 4'b0110, "en_low");
    add(1, 1, 4'b0000, 1,   1, 2, 4'b0110, "en_back");
    add(1, 1, 4'b0000, 1,   1, 1, 4'b0010, "en_next");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "en_done");
    add(1, 1, 4'b0100, 0,   1, 2, 4'b0100, "sc_setup");
    add(1, 1, 4'b0100, 1,   1, 2, 4'b0100, "sc_setwins");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "sc_done");
    add(1, 1, 4'b1111, 0,   1, 3, 4'b1111, "mr_setup");
    add(0, 1, 4'b0000, 0,   0, 0, 4'b0000, "mr_reset");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "mr_after0");
    add(1, 1, 4'b0000, 1,   0, 0, 4'b0000, "mr_after1");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].ready);
      check({vecs[i].name, ".valid"},   32'(valid),   32'(vecs[i].exp_valid));
      check({vecs[i].name, ".code"},    32'(code),    32'(vecs[i].exp_code));
      check({vecs[i].name, ".pending"}, 32'(pending), 32'(vecs[i].exp_pending));
    end

    // Back-to-back drain: one code per cycle, highest index first.
    step(1, 1, 4'b1111, 1);
    check("drain0.valid", 32'(valid), 32'd1);
    check("drain0.code", 32'(code), 32'd3);
    check("drain0.pending", 32'(pending), 32'hF);
    step(1, 1, 4'b0000, 1);
    check("drain1.code", 32'(code), 32'd2);
    check("drain1.pending", 32'(pending), 32'h7);
    step(1, 1, 4'b0000, 1);
    check("drain2.code", 32'(code), 32'd1);
    check("drain2.pending", 32'(pending), 32'h3);
    step(1, 1, 4'b0000, 1);
    check("drain3.valid", 32'(valid), 32'd1);
    check("drain3.code", 32'(code), 32'd0);
    check("drain3.pending", 32'(pending), 32'h1);
    step(1, 1, 4'b0000, 1);
    check("drain4.valid", 32'(valid), 32'd0);
    check("drain4.pending", 32'(pending), 32'h0);

    // Enable low with a held code and ready low: nothing captured or lost.
    step(1, 1, 4'b1001, 0);
    check("enhold0.code", 32'(code), 32'd3);
    step(1, 0, 4'b0110, 0);
    check("enhold1.valid", 32'(valid), 32'd0);
    check("enhold1.pending", 32'(pending), 32'h9);
    step(1, 1, 4'b0000, 1);
    check("enhold2.code", 32'(code), 32'd3);
    check("enhold2.valid", 32'(valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
